// File: rtl/stage_wr_pkg.sv
// Shared CPU constants and types for the write-back (WR) stage.
//   NUM_REGS / DATA_W / ADDR_W : register-file geometry
//   wr_latch_t                 : contents of the MEM/WR pipeline latch
//   WR_BUBBLE                  : latch value representing an empty slot
package stage_wr_pkg;

    localparam int NUM_REGS = 32;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;

    typedef struct packed {
        logic [DATA_W-1:0] dout;
        logic [DATA_W-1:0] alu_out;
        logic [ADDR_W-1:0] rw;
        logic              overflow;
        logic              mem_to_reg;
        logic              reg_wr;
        logic              valid;
    } wr_latch_t;

    localparam wr_latch_t WR_BUBBLE = '0;

endpackage

// File: rtl/stage_wr_regfile.sv
// RegFile: 32 x 32-bit register file with one write port and two
// combinational read ports that bypass the in-flight write.
// Ports:
//   Clk, Reset          clock, synchronous active-high reset (clears all regs)
//   we_i                write strobe (already qualified by the caller)
//   fwd_en_i            enables write-through bypass of waddr_i/wdata_i
//   waddr_i, wdata_i    write address / data
//   ra_i, rb_i          read addresses
//   rdata_a_o, rdata_b_o read data (register 0 always reads 0)
module RegFile
    import stage_wr_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              we_i,
    input  logic              fwd_en_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] ra_i,
    input  logic [ADDR_W-1:0] rb_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o
);

    // Whole-array reset is needed, so this maps to flops rather than RAM.
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    logic [ADDR_W-1:0] raddr [2];
    logic [DATA_W-1:0] rdata [2];

    assign raddr[0] = ra_i;
    assign raddr[1] = rb_i;

    // Register 0 is hard-wired; otherwise the pending write wins over the
    // stored value so a consumer sees it in the same cycle.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
        assign rdata[gi] = (raddr[gi] == '0) ? '0 :
                           (fwd_en_i && (raddr[gi] == waddr_i)) ? wdata_i :
                           regs_q[raddr[gi]];
    end

    assign rdata_a_o = rdata[0];
    assign rdata_b_o = rdata[1];

endmodule

// File: rtl/stage_wr.sv
// STAGE_WR: write-back stage. Holds the MEM/WR latch, selects write-back
// data, writes the register file once per latched instruction, raises the
// overflow-exception pulse and counts retired instructions.
// Ports:
//   Clk, Reset                    clock, synchronous active-high reset
//   WRin_*                        MEM-stage results and latch controls
//   ID_Ra, ID_Rb / ID_busA, ID_busB  bypassed register reads for decode
//   WRout_busW, WRout_Rw          latched write-back data / destination
//   WRout_RegWr                   effective register write enable
//   WRout_OvfExc                  overflow-exception pulse
//   WRout_Retired                 retired-instruction counter (wraps)
// RETIRED_INIT sets the counter's reset value; leave at 0 in a real CPU.
module stage_wr
    import stage_wr_pkg::*;
#(
    parameter logic [DATA_W-1:0] RETIRED_INIT = '0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] WRin_Dout,
    input  logic [DATA_W-1:0] WRin_ALUout,
    input  logic [ADDR_W-1:0] WRin_Rw,
    input  logic              WRin_Overflow,
    input  logic              WRin_MemtoReg,
    input  logic              WRin_RegWr,
    input  logic              WRin_Stall,
    input  logic              WRin_Flush,
    input  logic [ADDR_W-1:0] ID_Ra,
    input  logic [ADDR_W-1:0] ID_Rb,
    output logic [DATA_W-1:0] ID_busA,
    output logic [DATA_W-1:0] ID_busB,
    output logic [DATA_W-1:0] WRout_busW,
    output logic [ADDR_W-1:0] WRout_Rw,
    output logic              WRout_RegWr,
    output logic              WRout_OvfExc,
    output logic [DATA_W-1:0] WRout_Retired
);

    wr_latch_t         latch_q, latch_d;
    logic              written_q, written_d;
    logic [DATA_W-1:0] retired_q, retired_d;

    // The latched instruction still owes its write / count this cycle.
    logic pending;
    assign pending = latch_q.valid & ~written_q;

    always_comb begin
        latch_d   = latch_q;
        written_d = written_q;
        retired_d = retired_q;

        if (pending) begin
            retired_d = retired_q + DATA_W'(1);
        end

        if (WRin_Flush) begin
            latch_d   = WR_BUBBLE;
            written_d = 1'b0;
        end else if (WRin_Stall) begin
            // Held instruction has now completed; block repeat write/count.
            if (pending) begin
                written_d = 1'b1;
            end
        end else begin
            latch_d = '{dout:       WRin_Dout,
                        alu_out:    WRin_ALUout,
                        rw:         WRin_Rw,
                        overflow:   WRin_Overflow,
                        mem_to_reg: WRin_MemtoReg,
                        reg_wr:     WRin_RegWr,
                        valid:      1'b1};
            written_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            latch_q   <= WR_BUBBLE;
            written_q <= 1'b0;
            retired_q <= RETIRED_INIT;
        end else begin
            latch_q   <= latch_d;
            written_q <= written_d;
            retired_q <= retired_d;
        end
    end

    logic [DATA_W-1:0] bus_w;
    logic              reg_wr_eff;

    assign bus_w      = latch_q.mem_to_reg ? latch_q.dout : latch_q.alu_out;
    assign reg_wr_eff = latch_q.reg_wr & ~latch_q.overflow &
                        (latch_q.rw != '0) & latch_q.valid;

    RegFile u_regfile (
        .Clk       (Clk),
        .Reset     (Reset),
        .we_i      (reg_wr_eff & ~written_q),
        .fwd_en_i  (reg_wr_eff),
        .waddr_i   (latch_q.rw),
        .wdata_i   (bus_w),
        .ra_i      (ID_Ra),
        .rb_i      (ID_Rb),
        .rdata_a_o (ID_busA),
        .rdata_b_o (ID_busB)
    );

    assign WRout_busW    = bus_w;
    assign WRout_Rw      = latch_q.rw;
    assign WRout_RegWr   = reg_wr_eff;
    assign WRout_OvfExc  = pending & latch_q.reg_wr & latch_q.overflow;
    assign WRout_Retired = retired_q;

endmodule

// File: tb/tb_stage_wr.sv
// Self-checking bench for stage_wr: directed scenarios followed by random
// traffic, all compared against an instruction-level reference model.
// A second instance with the counter preset to 0xFFFFFFFF tracks wrap.
module tb_stage_wr;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] in_dout, in_alu;
    logic [4:0]  in_rw;
    logic        in_ovf, in_m2r, in_rwr, in_stall, in_flush;
    logic [4:0]  ra, rb;

    logic [31:0] bus_a, bus_b, bus_w, ret;
    logic [4:0]  rw_o;
    logic        regwr_o, ovf_o;

    logic [31:0] w_bus_a, w_bus_b, w_bus_w, w_ret;
    logic [4:0]  w_rw_o;
    logic        w_regwr_o, w_ovf_o;

    int n_tests = 0;
    int n_fail  = 0;

    stage_wr dut (
        .Clk(clk), .Reset(rst),
        .WRin_Dout(in_dout), .WRin_ALUout(in_alu), .WRin_Rw(in_rw),
        .WRin_Overflow(in_ovf), .WRin_MemtoReg(in_m2r), .WRin_RegWr(in_rwr),
        .WRin_Stall(in_stall), .WRin_Flush(in_flush),
        .ID_Ra(ra), .ID_Rb(rb), .ID_busA(bus_a), .ID_busB(bus_b),
        .WRout_busW(bus_w), .WRout_Rw(rw_o), .WRout_RegWr(regwr_o),
        .WRout_OvfExc(ovf_o), .WRout_Retired(ret)
    );

    stage_wr #(.RETIRED_INIT(32'hFFFF_FFFF)) u_wrap (
        .Clk(clk), .Reset(rst),
        .WRin_Dout(in_dout), .WRin_ALUout(in_alu), .WRin_Rw(in_rw),
        .WRin_Overflow(in_ovf), .WRin_MemtoReg(in_m2r), .WRin_RegWr(in_rwr),
        .WRin_Stall(in_stall), .WRin_Flush(in_flush),
        .ID_Ra(ra), .ID_Rb(rb), .ID_busA(w_bus_a), .ID_busB(w_bus_b),
        .WRout_busW(w_bus_w), .WRout_Rw(w_rw_o), .WRout_RegWr(w_regwr_o),
        .WRout_OvfExc(w_ovf_o), .WRout_Retired(w_ret)
    );

    // ---------------- reference model (one instruction at a time) -------
    typedef struct packed {
        logic [31:0] dout;
        logic [31:0] alu;
        logic [4:0]  rw;
        logic        ovf;
        logic        m2r;
        logic        rwr;
        logic        valid;
    } instr_t;

    instr_t      cur;
    bit          done;           // current instruction already completed
    logic [31:0] mregs [32];
    logic [31:0] mret;

    function automatic logic [31:0] m_busw();
        return cur.m2r ? cur.dout : cur.alu;
    endfunction

    function automatic logic m_wr_en();
        return cur.valid && cur.rwr && !cur.ovf && (cur.rw != 5'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (m_wr_en() && a == cur.rw) return m_busw();
        return mregs[a];
    endfunction

    task automatic model_edge();
        if (rst) begin
            cur  = '0;
            done = 1'b0;
            foreach (mregs[i]) mregs[i] = 32'd0;
            mret = 32'd0;
        end else begin
            if (cur.valid && !done) begin
                mret = mret + 32'd1;
                if (m_wr_en()) mregs[cur.rw] = m_busw();
            end
            if (in_flush) begin
                cur  = '0;
                done = 1'b0;
            end else if (in_stall) begin
                if (cur.valid) done = 1'b1;
            end else begin
                cur  = '{in_dout, in_alu, in_rw, in_ovf, in_m2r, in_rwr, 1'b1};
                done = 1'b0;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("busW",         bus_w, m_busw());
        check("Rw",           32'(rw_o), 32'(cur.rw));
        check("RegWr",        32'(regwr_o), 32'(m_wr_en()));
        check("OvfExc",       32'(ovf_o), 32'(cur.valid && cur.rwr && cur.ovf && !done));
        check("Retired",      ret, mret);
        check("wrap_Retired", w_ret, mret + 32'hFFFF_FFFF);
        check("busA",         bus_a, m_read(ra));
        check("busB",         bus_b, m_read(rb));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic put_instr(input logic [31:0] d, input logic [31:0] a, input logic [4:0] r,
                             input logic o, input logic m, input logic w);
        in_dout = d; in_alu = a; in_rw = r;
        in_ovf = o; in_m2r = m; in_rwr = w;
        in_stall = 1'b0; in_flush = 1'b0;
    endtask

    task automatic put_bubble();
        put_instr($urandom, $urandom, 5'($urandom), 1'b0, 1'b0, 1'b1);
        in_flush = 1'b1;
    endtask

    initial begin
        rst = 1'b1; ra = 5'd0; rb = 5'd0;
        put_instr(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);

        // reset state
        step();
        check("reset_Retired", ret, 32'd0);
        check("reset_wrap_Retired", w_ret, 32'hFFFF_FFFF);
        check("reset_busW", bus_w, 32'd0);
        rst = 1'b0;

        // write from ALU, visible from the register after two edges
        put_instr(32'd0, 32'h1234_5678, 5'd5, 1'b0, 1'b0, 1'b1); ra = 5'd5;
        step();
        check("alu_bypass_busA", bus_a, 32'h1234_5678);
        put_bubble();
        step();
        check("alu_reg_busA", bus_a, 32'h1234_5678);
        check("alu_Retired", ret, 32'd1);
        check("wrap_to_zero", w_ret, 32'd0);

        // load with same-cycle bypass on port B
        put_instr(32'hDEAD_BEEF, 32'd0, 5'd7, 1'b0, 1'b1, 1'b1); rb = 5'd7;
        step();
        check("load_bypass_busB", bus_b, 32'hDEAD_BEEF);
        put_bubble();
        step();

        // overflow suppresses the write but still retires
        put_instr(32'd0, 32'h0000_AAAA, 5'd3, 1'b1, 1'b0, 1'b1); ra = 5'd3;
        step();
        check("ovf_OvfExc_on", 32'(ovf_o), 32'd1);
        check("ovf_RegWr", 32'(regwr_o), 32'd0);
        put_bubble();
        step();
        check("ovf_OvfExc_off", 32'(ovf_o), 32'd0);
        check("ovf_reg3", bus_a, 32'd0);
        check("ovf_Retired", ret, 32'd3);

        // write to r0 is dropped
        put_instr(32'd0, 32'hFFFF_FFFF, 5'd0, 1'b0, 1'b0, 1'b1); ra = 5'd0;
        step();
        check("r0_busA", bus_a, 32'd0);
        check("r0_RegWr", 32'(regwr_o), 32'd0);
        put_bubble();
        step();

        // three-cycle stall: one write, one count
        put_instr(32'd0, 32'h0000_9999, 5'd9, 1'b0, 1'b0, 1'b1); ra = 5'd9;
        step();
        for (int k = 0; k < 3; k++) begin
            put_instr($urandom, $urandom, 5'($urandom), 1'b0, 1'b0, 1'b1);
            in_stall = 1'b1;
            step();
            check("stall_Retired", ret, 32'd5);
            check("stall_Rw", 32'(rw_o), 32'd9);
        end
        put_bubble();
        step();
        check("stall_reg9", bus_a, 32'h0000_9999);
        check("stall_Retired_after", ret, 32'd5);

        // flush beats stall
        put_instr(32'd0, 32'h5555_5555, 5'd10, 1'b0, 1'b0, 1'b1); ra = 5'd10;
        in_stall = 1'b1; in_flush = 1'b1;
        step();
        check("flushstall_RegWr", 32'(regwr_o), 32'd0);
        check("flushstall_busW", bus_w, 32'd0);
        in_flush = 1'b0;
        step();
        check("flushstall_Retired", ret, 32'd5);
        check("flushstall_reg10", bus_a, 32'd0);

        // reset while stalled: held instruction is discarded
        put_instr(32'd0, 32'h7777_7777, 5'd12, 1'b0, 1'b0, 1'b1); ra = 5'd12;
        step();
        check("rststall_bypass", bus_a, 32'h7777_7777);
        in_stall = 1'b1; rst = 1'b1;
        step();
        check("rststall_reg12", bus_a, 32'd0);
        check("rststall_Retired", ret, 32'd0);
        rst = 1'b0; ra = 5'd5; rb = 5'd9;
        put_bubble();
        step();
        check("rststall_reg5", bus_a, 32'd0);
        check("rststall_reg9", bus_b, 32'd0);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            put_instr($urandom, $urandom, 5'($urandom_range(0, 7)),
                      1'($urandom_range(0, 99) < 20), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 99) < 80));
            in_stall = 1'($urandom_range(0, 99) < 30);
            in_flush = 1'($urandom_range(0, 99) < 10);
            rst      = 1'($urandom_range(0, 99) < 2);
            ra       = 5'($urandom_range(0, 7));
            rb       = ($urandom_range(0, 1) == 1) ? cur.rw : 5'($urandom_range(0, 7));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stage_wr.md
STAGE_WR -- requirements
Module: STAGE_WR

Interface
REQ-001 The module SHALL have these ports: name  direction  width  meaning.
- Clk  in  1  single clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- WRin_Dout  in  32  data-memory read data from MEM stage.
- WRin_ALUout  in  32  ALU result from MEM stage.
- WRin_Rw  in  5  destination register from MEM stage.
- WRin_Overflow  in  1  ALU overflow flag from MEM stage.
- WRin_MemtoReg  in  1  1 = write back memory data.
- WRin_RegWr  in  1  register write enable from MEM stage.
- WRin_Stall  in  1  hold MEM/WR latch contents.
- WRin_Flush  in  1  load a bubble into MEM/WR latch.
- ID_Ra  in  5  register-file read address A.
- ID_Rb  in  5  register-file read address B.
- ID_busA  out  32  read data A, combinational.
- ID_busB  out  32  read data B, combinational.
- WRout_busW  out  32  selected write-back data, for forwarding.
- WRout_Rw  out  5  latched destination register.
- WRout_RegWr  out  1  effective register write enable.
- WRout_OvfExc  out  1  overflow-exception pulse.
- WRout_Retired  out  32  retired-instruction counter.
REQ-002 The design SHALL use one clock, Clk, and one reset, Reset, which is synchronous and active-high.

Function
REQ-003 The MEM/WR latch (Dout, ALUout, Rw, Overflow, MemtoReg, RegWr, Valid) SHALL load the WRin_* values on each posedge Clk when Stall=0 and Flush=0. Valid loads 1 on such a cycle.
REQ-004 If Stall=1 and Flush=0, the latch SHALL hold its contents.
REQ-005 Flush=1 SHALL load a bubble (all latch fields 0, Valid=0). Flush has priority over Stall.
REQ-006 WRout_busW SHALL equal latched MemtoReg ? Dout : ALUout.
REQ-007 WRout_RegWr SHALL equal RegWr & ~Overflow & (Rw != 0) & Valid.
REQ-008 The register file SHALL hold 32x32-bit registers. When WRout_RegWr=1, register[Rw] SHALL be written with WRout_busW on posedge Clk. The write SHALL occur even during Stall, but only once per latched instruction (see REQ-009).
REQ-009 A Written flag SHALL set after a write while stalled. It SHALL suppress further writes and counts until the latch reloads.
REQ-010 Register 0 SHALL always read 0 and SHALL never be written.
REQ-011 Read ports SHALL use write-through bypass: if WRout_RegWr=1 and ID_Ra==WRout_Rw (nonzero), then ID_busA=WRout_busW. The same rule SHALL apply to ID_Rb/ID_busB.
REQ-012 WRout_OvfExc SHALL be 1 for exactly the cycle(s) the latch holds Valid & RegWr & Overflow, with Written=0.
REQ-013 WRout_Retired SHALL increment by 1 on posedge Clk when Valid=1 and Written=0, then set Written if stalled. It SHALL wrap from 0xFFFFFFFF to 0.
REQ-014 Latency SHALL be 1 cycle from MEM-stage outputs to register-file update. There SHALL be 0 cycles from register write to visible read, via bypass.

Reset
REQ-015 With Reset=1 at posedge Clk:
- the latch SHALL clear to a bubble;
- Written SHALL be 0;
- all 32 registers SHALL be 0;
- WRout_Retired SHALL be 0.
REQ-016 Reset SHALL take priority over Stall, Flush and any pending write. After reset, all outputs SHALL be 0.
REQ-017 Reset asserted mid-stall SHALL discard the held instruction with no register write and no count.

Structure
REQ-018 Register count (32), data width (32) and address width (5) SHALL be defined as constants in the shared CPU package.
REQ-019 The register file SHALL be a sub-module, RegFile, with the write port and the two bypassed read ports. The latch, mux, Written flag and counter SHALL stay in STAGE_WR.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Write from ALU: Rw=5, ALUout=0x12345678, RegWr=1, MemtoReg=0 → after 2 edges, ID_Ra=5 reads 0x12345678; Retired=1.
- Load with same-cycle bypass: Rw=7, Dout=0xDEADBEEF, MemtoReg=1 → in the same cycle the latch holds it, ID_Rb=7 returns 0xDEADBEEF.
- Overflow suppress: Rw=3, Overflow=1, RegWr=1 → reg3 stays 0; OvfExc=1 for one cycle; Retired still increments.
- Rw=0 write: ALUout=0xFFFFFFFF → ID_Ra=0 reads 0; WRout_RegWr=0.
- Stall for 3 cycles holding Rw=9 → exactly one write; Retired +1 only. Flush+Stall together → bubble, Valid=0.
- Retired preset near wrap (0xFFFFFFFF) plus one instruction → counter becomes 0. Reset mid-stall → all registers 0, Retired 0, no write.
